pc_predict: RTL and testbench

PC_PREDICT -- requirements
Module: pc_predict

---
 rtl/pc_predict_if.sv | 42 ++++
 rtl/pc_predict.sv | 78 +++++++
 tb/tb_pc_predict.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pc_predict_if.sv
// pc_predict_if: fetch/memory/write-back signals feeding the PC predictor and its outputs
interface pc_predict_if #(
    parameter int ADDR_W    = 64,
    parameter int RAS_DEPTH = 8
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    logic              f_valid;
    logic              f_stall;
    logic [3:0]        f_icode;
    logic [3:0]        f_ifun;
    logic [ADDR_W-1:0] f_valC;
    logic [ADDR_W-1:0] f_valP;
    logic              m_valid;
    logic [3:0]        m_icode;
    logic [3:0]        m_ifun;
    logic              m_cnd;
    logic [ADDR_W-1:0] m_valA;
    logic [ADDR_W-1:0] m_valC;
    logic              w_valid;
    logic [3:0]        w_icode;
    logic [ADDR_W-1:0] w_valM;
    logic [ADDR_W-1:0] w_ret_pred;
    logic [ADDR_W-1:0] f_pc;
    logic [ADDR_W-1:0] pred_pc;
    logic [ADDR_W-1:0] f_ret_pred;
    logic              redirect;
    logic [CW-1:0]     ras_count;

    modport master (
        output f_valid, f_stall, f_icode, f_ifun, f_valC, f_valP,
               m_valid, m_icode, m_ifun, m_cnd, m_valA, m_valC,
               w_valid, w_icode, w_valM, w_ret_pred,
        input  f_pc, pred_pc, f_ret_pred, redirect, ras_count
    );

    modport slave (
        input  f_valid, f_stall, f_icode, f_ifun, f_valC, f_valP,
               m_valid, m_icode, m_ifun, m_cnd, m_valA, m_valC,
               w_valid, w_icode, w_valM, w_ret_pred,
        output f_pc, pred_pc, f_ret_pred, redirect, ras_count
    );
endinterface

// File: rtl/pc_predict.sv
// pc_predict: next-fetch-PC predictor with return-address stack and late correction
module pc_predict #(
    parameter int                ADDR_W       = 64,
    parameter int                RAS_DEPTH    = 8,
    parameter int                PREDICT_MODE = 1,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input logic         clk,
    input logic         reset,
    pc_predict_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]     ptr;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pred;
    logic [ADDR_W-1:0] jxx_target;
    logic              ret_mis;
    logic              jxx_mis;
    logic              corr;
    logic              advance;
    logic              push;
    logic              pop;

    // Prediction, misprediction detection and RAS push/pop decode
    always_comb begin
        pred       = (bus.f_icode == 4'd8 || (bus.f_icode == 4'd7 && (bus.f_ifun == 4'd0 || PREDICT_MODE != 0))) ? bus.f_valC :
                     (bus.f_icode == 4'd9 && cnt != '0) ? ras[ptr - PW'(1)] : bus.f_valP;
        ret_mis    = bus.w_valid && bus.w_icode == 4'd9 && bus.w_valM != bus.w_ret_pred;
        jxx_mis    = bus.m_valid && bus.m_icode == 4'd7 && bus.m_ifun != 4'd0 && (PREDICT_MODE != 0 ? !bus.m_cnd : bus.m_cnd);
        jxx_target = PREDICT_MODE != 0 ? bus.m_valA : bus.m_valC;
        corr       = !reset && (ret_mis || jxx_mis);
        advance    = bus.f_valid && !bus.f_stall && !corr;
        push       = advance && bus.f_icode == 4'd8;
        pop        = advance && bus.f_icode == 4'd9;
    end

    // Fetch PC: reset, then ret correction, then jXX correction, then stall/advance
    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= RESET_PC;
        else if (ret_mis)
            pc_q <= bus.w_valM;
        else if (jxx_mis)
            pc_q <= jxx_target;
        else if (bus.f_valid && !bus.f_stall)
            pc_q <= pred;
    end

    // Circular RAS pointer and saturating occupancy; pop on empty is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            cnt <= (cnt == CW'(RAS_DEPTH)) ? cnt : cnt + CW'(1);
        end else if (pop && cnt != '0) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

    // RAS storage needs no reset; a full stack overwrites its oldest slot
    always_ff @(posedge clk) begin
        if (!reset && push)
            ras[ptr] <= bus.f_valP;
    end

    assign bus.f_pc       = pc_q;
    assign bus.pred_pc    = pred;
    assign bus.f_ret_pred = bus.f_icode == 4'd9 ? pred : '0;
    assign bus.redirect   = corr;
    assign bus.ras_count  = cnt;
endmodule

// File: tb/tb_pc_predict.sv
// tb_pc_predict: directed scoreboard bench for pc_predict (64-bit, 8-deep RAS, predict-taken)
module tb_pc_predict;
    logic clk = 0;
    logic reset = 1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int          cyc;
        int          sel;
        string       name;
        logic [63:0] val;
    } exp_t;
    exp_t q[$];

    pc_predict_if #(.ADDR_W(64), .RAS_DEPTH(8)) bus ();
    pc_predict #(.ADDR_W(64), .RAS_DEPTH(8), .PREDICT_MODE(1), .RESET_PC(64'h0)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue an expectation for the cycle dc cycles from now
    task automatic exp_push(input int dc, input int sel, input string name, input logic [63:0] v);
        exp_t e;
        e.cyc  = cyc + dc;
        e.sel  = sel;
        e.name = name;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.f_valid = 0; bus.f_stall = 0; bus.f_icode = 0; bus.f_ifun = 0;
        bus.f_valC = 0; bus.f_valP = 0;
        bus.m_valid = 0; bus.m_icode = 0; bus.m_ifun = 0; bus.m_cnd = 0;
        bus.m_valA = 0; bus.m_valC = 0;
        bus.w_valid = 0; bus.w_icode = 0; bus.w_valM = 0; bus.w_ret_pred = 0;
    endtask

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        exp_t keep[$];
        logic [63:0] act;
        keep = {};
        foreach (q[i]) begin
            if (q[i].cyc == cyc) begin
                act = q[i].sel == 0 ? bus.f_pc :
                      q[i].sel == 1 ? bus.pred_pc :
                      q[i].sel == 2 ? bus.f_ret_pred :
                      q[i].sel == 3 ? 64'(bus.redirect) : 64'(bus.ras_count);
                total++;
                if (act !== q[i].val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", q[i].name, cyc, act, q[i].val);
                end
            end else begin
                keep.push_back(q[i]);
            end
        end
        q = keep;
    end

    initial begin
        idle();
        reset = 1;
        bus.f_valid = 1; bus.f_icode = 1; bus.f_valP = 64'h0A;
        step();
        exp_push(0, 0, "reset_pc", 64'h0);
        exp_push(0, 4, "reset_ras", 0);
        reset = 0;
        exp_push(0, 1, "seq_pred", 64'h0A);
        exp_push(0, 3, "seq_noredir", 0);
        exp_push(1, 0, "seq_pc", 64'h0A);
        step();
        bus.f_icode = 8; bus.f_valC = 64'h100; bus.f_valP = 64'h20;
        exp_push(0, 1, "call_pred", 64'h100);
        exp_push(0, 2, "call_retpred0", 0);
        exp_push(1, 0, "call_pc", 64'h100);
        exp_push(1, 4, "call_cnt", 1);
        step();
        bus.f_icode = 9; bus.f_valC = 0; bus.f_valP = 64'h102;
        exp_push(0, 1, "ret_pred", 64'h20);
        exp_push(0, 2, "ret_retpred", 64'h20);
        exp_push(1, 0, "ret_pc", 64'h20);
        exp_push(1, 4, "ret_cnt", 0);
        step();
        bus.f_icode = 7; bus.f_ifun = 1; bus.f_valC = 64'h40; bus.f_valP = 64'h29;
        exp_push(0, 1, "jxx_pred", 64'h40);
        exp_push(1, 0, "jxx_pc", 64'h40);
        step();
        bus.f_stall = 1; bus.f_icode = 8; bus.f_ifun = 0; bus.f_valC = 64'h600; bus.f_valP = 64'h44;
        bus.m_valid = 1; bus.m_icode = 7; bus.m_ifun = 1; bus.m_cnd = 0;
        bus.m_valA = 64'h15; bus.m_valC = 64'h40;
        exp_push(0, 3, "jxx_redir", 1);
        exp_push(1, 0, "jxx_fix_pc", 64'h15);
        exp_push(1, 4, "jxx_nopush", 0);
        step();
        bus.m_cnd = 1;
        exp_push(0, 3, "jxx_ok_noredir", 0);
        exp_push(1, 0, "stall_hold", 64'h15);
        exp_push(1, 4, "stall_nopush", 0);
        step();
        bus.f_stall = 0; bus.f_valid = 0; bus.m_ifun = 0; bus.m_cnd = 0;
        exp_push(0, 3, "jmp_noredir", 0);
        exp_push(1, 0, "invalid_hold", 64'h15);
        step();
        bus.m_ifun = 2; bus.m_cnd = 0; bus.m_valA = 64'h15;
        bus.w_valid = 1; bus.w_icode = 9; bus.w_valM = 64'h80; bus.w_ret_pred = 64'h20;
        exp_push(0, 3, "both_redir", 1);
        exp_push(1, 0, "ret_wins", 64'h80);
        step();
        bus.m_valid = 0; bus.w_ret_pred = 64'h80;
        exp_push(0, 3, "ret_ok_noredir", 0);
        step();
        idle();
        bus.f_valid = 1;
        for (int i = 1; i <= 9; i++) begin
            bus.f_icode = 8; bus.f_valC = 64'h200 + 64'(i); bus.f_valP = 64'(i);
            step();
        end
        exp_push(0, 4, "ras_full", 8);
        for (int k = 0; k < 9; k++) begin
            bus.f_icode = 9; bus.f_valC = 0; bus.f_valP = 64'h300 + 64'(k);
            exp_push(0, 1, "ras_pop_pred", k < 8 ? 64'(9 - k) : 64'h300 + 64'(k));
            exp_push(0, 4, "ras_pop_cnt", k < 8 ? 64'(8 - k) : 0);
            step();
        end
        exp_push(0, 4, "ras_empty", 0);
        bus.f_icode = 8; bus.f_valC = 64'h700; bus.f_valP = 64'h50;
        exp_push(1, 4, "pre_reset_cnt", 1);
        step();
        reset = 1;
        bus.f_valC = 64'h500; bus.f_valP = 64'h55;
        exp_push(1, 0, "reset_call_pc", 64'h0);
        exp_push(1, 4, "reset_call_cnt", 0);
        step();
        reset = 0;
        idle();
        repeat (3) step();
        if (q.size() != 0) begin
            $display("FAIL pending got=%0d want=0 unchecked expectations", q.size());
            total += q.size();
            bad += q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
